pilot_extract: RTL and testbench

// - Receive-side counterpart of the transmit pilot inserter. Sits downstream of it and consumes its 32-bit sample stream.
// - Strips pilot samples at fixed positions, forwards data samples over a valid/ready interface, and presents pilots on a side port.
// - Compares each pilot with the expected value and flags mismatches and frame-sync loss.

---
 rtl/pilot_extract.sv | 198 +++++++++++++++++++
 tb/tb_pilot_extract.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pilot_extract.sv
// pilot_extract
//   Receive-side pilot remover. Tracks frame and pilot position on every
//   accepted sample, strips pilots from the data stream (or tags them when
//   forwarded), publishes each pilot on a side port and compares it with the
//   expected pilot value.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   signal_in       32-bit sample, [31:16]=I, [15:0]=Q (signed)
//   valid_in        upstream valid; ready_out upstream ready (registered)
//   frame_start     marks sample index 0 (qualified by accept)
//   frame_length    samples per frame incl. pilots, 0 = unbounded
//   pilot_interval  pilot period, 0 = no pilots
//   pilot_value     expected pilot sample
//   data_out        data sample; valid_out / ready_in downstream handshake
//   pilot_out       last received pilot; pilot_valid 1-cycle update pulse
//   pilot_mismatch  pulse with pilot_valid when |dI|+|dQ| > PILOT_TOL
//   mm_count        saturating mismatch count, cleared at each frame start
//   frame_end       pulse when the last sample of a frame is accepted
//   error           pulse when frame_start arrives mid-frame (resync)
//   data_is_pilot   (PILOT_EXTRACT_PASS_EN only) data_out carries a pilot
//
// Build option
//   PILOT_EXTRACT_PASS_EN  forward pilots on data_out as well, tagged by
//                          data_is_pilot.

module pilot_extract #(
   parameter int unsigned PILOT_TOL = 64,
   parameter int unsigned MM_CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         signal_in,
   input  logic                valid_in,
   output logic                ready_out,
   input  logic                frame_start,
   input  logic [12:0]         frame_length,
   input  logic [12:0]         pilot_interval,
   input  logic [31:0]         pilot_value,
   output logic [31:0]         data_out,
   output logic                valid_out,
   input  logic                ready_in,
   output logic [31:0]         pilot_out,
   output logic                pilot_valid,
   output logic                pilot_mismatch,
   output logic [MM_CNT_W-1:0] mm_count,
   output logic                frame_end,
   output logic                error
`ifdef PILOT_EXTRACT_PASS_EN
   ,
   output logic                data_is_pilot
`endif
);

`ifdef PILOT_EXTRACT_PASS_EN
   localparam bit          PASS = 1'b1;
   localparam int unsigned EW   = 33;
`else
   localparam bit          PASS = 1'b0;
   localparam int unsigned EW   = 32;
`endif

   // position / configuration state
   logic [12:0]         cnt_frame, cnt_pilot;
   logic [12:0]         lat_len, lat_int;
   logic [31:0]         lat_pv;

   // skid buffer: output register plus one skid entry
   logic [EW-1:0]       out_word, sk_word;
   logic                out_v, sk_v;

   // combinational decode of the sample currently offered
   logic                accept, idx0, is_pilot, wrap, mism, push, pop;
   logic [12:0]         eff_len, eff_int, eff_fcnt, eff_pcnt;
   logic [12:0]         fcnt_nxt, pcnt_nxt;
   logic [31:0]         eff_pv;
   logic [16:0]         d_i, d_q, abs_i, abs_q;
   logic [17:0]         dev_sum;
   logic [MM_CNT_W-1:0] mm_base, mm_nxt;
   logic [EW-1:0]       push_word;

   logic [EW-1:0]       out_word_n, sk_word_n;
   logic                out_v_n, sk_v_n;

   // Index 0 is either the sample after a wrap/reset or any frame_start; on
   // that sample the live config inputs are used directly and also latched.
   // With frame_length == 0 cnt_frame rolls over after 8192 samples, which
   // simply restarts positioning like a frame start without an error.
   always_comb begin
      accept   = valid_in & ready_out;
      idx0     = (cnt_frame == '0) | frame_start;
      eff_len  = idx0 ? frame_length   : lat_len;
      eff_int  = idx0 ? pilot_interval : lat_int;
      eff_pv   = idx0 ? pilot_value    : lat_pv;
      eff_fcnt = idx0 ? '0 : cnt_frame;
      eff_pcnt = idx0 ? '0 : cnt_pilot;

      is_pilot = (eff_int != '0) && (eff_pcnt == '0);
      wrap     = (eff_len != '0) && (eff_fcnt == eff_len - 13'd1);
      fcnt_nxt = wrap ? '0 : eff_fcnt + 13'd1;
      pcnt_nxt = ((eff_int == '0) || (eff_pcnt == eff_int - 13'd1)) ? '0 : eff_pcnt + 13'd1;

      d_i     = {signal_in[31], signal_in[31:16]} - {eff_pv[31], eff_pv[31:16]};
      d_q     = {signal_in[15], signal_in[15:0]}  - {eff_pv[15], eff_pv[15:0]};
      abs_i   = d_i[16] ? (17'd0 - d_i) : d_i;
      abs_q   = d_q[16] ? (17'd0 - d_q) : d_q;
      dev_sum = {1'b0, abs_i} + {1'b0, abs_q};
      mism    = dev_sum > 18'(PILOT_TOL);

      mm_base = idx0 ? '0 : mm_count;
      mm_nxt  = mm_base;
      if (is_pilot && mism && (mm_base != '1))
         mm_nxt = mm_base + MM_CNT_W'(1);

      push = accept & (~is_pilot | PASS);
`ifdef PILOT_EXTRACT_PASS_EN
      push_word = {is_pilot, signal_in};
`else
      push_word = signal_in;
`endif
   end

   // skid buffer next state; ready_out == !sk_v guarantees no push into a
   // full skid entry while the output register is stalled
   always_comb begin
      pop        = out_v & ready_in;
      out_word_n = out_word;
      out_v_n    = out_v;
      sk_word_n  = sk_word;
      sk_v_n     = sk_v;
      if (!out_v || pop) begin
         if (sk_v) begin
            out_word_n = sk_word;
            out_v_n    = 1'b1;
            sk_v_n     = push;
            if (push)
               sk_word_n = push_word;
         end else begin
            out_v_n = push;
            if (push)
               out_word_n = push_word;
         end
      end else if (push) begin
         sk_word_n = push_word;
         sk_v_n    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_frame      <= '0;
         cnt_pilot      <= '0;
         lat_len        <= '0;
         lat_int        <= '0;
         lat_pv         <= '0;
         out_word       <= '0;
         sk_word        <= '0;
         out_v          <= 1'b0;
         sk_v           <= 1'b0;
         ready_out      <= 1'b0;
         pilot_out      <= '0;
         pilot_valid    <= 1'b0;
         pilot_mismatch <= 1'b0;
         mm_count       <= '0;
         frame_end      <= 1'b0;
         error          <= 1'b0;
      end else begin
         out_word       <= out_word_n;
         out_v          <= out_v_n;
         sk_word        <= sk_word_n;
         sk_v           <= sk_v_n;
         ready_out      <= ~sk_v_n;
         pilot_valid    <= accept & is_pilot;
         pilot_mismatch <= accept & is_pilot & mism;
         frame_end      <= accept & wrap;
         error          <= accept & frame_start & (cnt_frame != '0);
         if (accept) begin
            cnt_frame <= fcnt_nxt;
            cnt_pilot <= pcnt_nxt;
            mm_count  <= mm_nxt;
            if (idx0) begin
               lat_len <= frame_length;
               lat_int <= pilot_interval;
               lat_pv  <= pilot_value;
            end
            if (is_pilot)
               pilot_out <= signal_in;
         end
      end
   end

   assign data_out  = out_word[31:0];
   assign valid_out = out_v;
`ifdef PILOT_EXTRACT_PASS_EN
   assign data_is_pilot = out_word[32];
`endif

endmodule

// File: tb/tb_pilot_extract.sv
// tb_pilot_extract
//   Directed bench for pilot_extract: ramp frame, pilot deviation limits,
//   backpressure through the skid buffer, mid-frame resync, reset with a full
//   buffer and the every-sample-is-a-pilot case. Data-path expectations are
//   queued as each sample is sent (hand-marked pilot flag) and compared with
//   the transfers seen at data_out. Honors PILOT_EXTRACT_PASS_EN.

module tb_pilot_extract;

`ifdef PILOT_EXTRACT_PASS_EN
   localparam bit PASS = 1'b1;
`else
   localparam bit PASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] signal_in;
   logic        valid_in;
   logic        ready_out;
   logic        frame_start;
   logic [12:0] frame_length;
   logic [12:0] pilot_interval;
   logic [31:0] pilot_value;
   logic [31:0] data_out;
   logic        valid_out;
   logic        ready_in;
   logic [31:0] pilot_out;
   logic        pilot_valid;
   logic        pilot_mismatch;
   logic [7:0]  mm_count;
   logic        frame_end;
   logic        error;
`ifdef PILOT_EXTRACT_PASS_EN
   logic        data_is_pilot;
`endif

   pilot_extract #(.PILOT_TOL(64), .MM_CNT_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .signal_in      (signal_in),
      .valid_in       (valid_in),
      .ready_out      (ready_out),
      .frame_start    (frame_start),
      .frame_length   (frame_length),
      .pilot_interval (pilot_interval),
      .pilot_value    (pilot_value),
      .data_out       (data_out),
      .valid_out      (valid_out),
      .ready_in       (ready_in),
      .pilot_out      (pilot_out),
      .pilot_valid    (pilot_valid),
      .pilot_mismatch (pilot_mismatch),
      .mm_count       (mm_count),
      .frame_end      (frame_end),
      .error          (error)
`ifdef PILOT_EXTRACT_PASS_EN
      ,
      .data_is_pilot  (data_is_pilot)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int pv_cnt  = 0;
   int fe_cnt  = 0;
   int err_cnt = 0;

   logic [31:0] exp_q[$];
   logic        exp_f[$];
   logic [31:0] obs_q[$];
   logic        obs_f[$];

   // outputs are stable at the falling edge; a transfer seen here completes
   // on the next rising edge
   always @(negedge clk) begin
      if (valid_out && ready_in) begin
         obs_q.push_back(data_out);
`ifdef PILOT_EXTRACT_PASS_EN
         obs_f.push_back(data_is_pilot);
`endif
      end
      if (pilot_valid) pv_cnt++;
      if (frame_end)   fe_cnt++;
      if (error)       err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // offer one sample until accepted; returns 1 time unit after the accepting edge
   task automatic send(input logic [31:0] s, input logic fs, input logic pil);
      int   n  = 0;
      logic ok = 1'b0;
      signal_in   = s;
      frame_start = fs;
      valid_in    = 1'b1;
      do begin
         @(negedge clk);
         ok = ready_out;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 200);
      valid_in    = 1'b0;
      frame_start = 1'b0;
      if (!ok)
         check("send_timeout", 32'd0, 32'd1);
      else if (PASS || !pil) begin
         exp_q.push_back(s);
         exp_f.push_back(pil);
      end
   endtask

   task automatic drain_check(input string tag);
      idle(4);
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         check({tag, "_data"}, obs_q.pop_front(), exp_q.pop_front());
`ifdef PILOT_EXTRACT_PASS_EN
         if (obs_f.size() > 0)
            check({tag, "_flag"}, obs_f.pop_front(), exp_f.pop_front());
`endif
      end
      exp_q.delete(); exp_f.delete(); obs_q.delete(); obs_f.delete();
   endtask

   int pv0, fe0, er0;

   initial begin
      rst = 1'b1; valid_in = 1'b0; frame_start = 1'b0; signal_in = '0;
      ready_in = 1'b1; frame_length = 13'd16; pilot_interval = 13'd4; pilot_value = '0;

      // reset
      idle(3);
      check("rst_ready", ready_out, 1'b0);
      check("rst_valid", valid_out, 1'b0);
      rst = 1'b0;
      idle(1);
      check("rst_ready_release", ready_out, 1'b1);
      check("rst_mm", mm_count, 8'd0);

      // ramp frame, interval 4, length 16
      pv0 = pv_cnt; fe0 = fe_cnt; er0 = err_cnt;
      for (int k = 0; k < 16; k++) begin
         send(32'(k), k == 0, (k % 4) == 0);
         if (k == 0)  check("ramp_pv0", pilot_valid, 1'b1);
         if (k == 12) check("ramp_pilot12", pilot_out, 32'd12);
         if (k == 14) check("ramp_fe_early", frame_end, 1'b0);
         if (k == 15) check("ramp_fe", frame_end, 1'b1);
      end
      drain_check("ramp");
      check("ramp_npilot", pv_cnt - pv0, 4);
      check("ramp_nfe", fe_cnt - fe0, 1);
      check("ramp_nerr", err_cnt - er0, 0);

      // pilot deviation: 128 > 64 mismatches, exactly 64 does not
      frame_length = 13'd8;
      send(32'h0040_0040, 1'b1, 1'b1);
      check("mm_pulse", pilot_mismatch, 1'b1);
      check("mm_cnt1", mm_count, 8'd1);
      for (int k = 1; k < 4; k++) send(32'h0000_1000 + 32'(k), 1'b0, 1'b0);
      send(32'h0020_0020, 1'b0, 1'b1);
      check("tol_eq_pv", pilot_valid, 1'b1);
      check("tol_eq_mm", pilot_mismatch, 1'b0);
      check("tol_eq_cnt", mm_count, 8'd1);
      for (int k = 5; k < 8; k++) send(32'h0000_1000 + 32'(k), 1'b0, 1'b0);
      // new frame: count cleared, negative deviation of 64 not a mismatch
      frame_length = 13'd4;
      send(32'hFFE0_FFE0, 1'b1, 1'b1);
      check("neg_mm", pilot_mismatch, 1'b0);
      check("neg_cnt_clear", mm_count, 8'd0);
      for (int k = 1; k < 4; k++) send(32'h0000_2000 + 32'(k), 1'b0, 1'b0);
      // nonzero pilot_value: dI=32, dQ=33 -> 65
      pilot_value = 32'h0010_0010;
      send(32'h0030_0031, 1'b1, 1'b1);
      check("tol65_mm", pilot_mismatch, 1'b1);
      check("tol65_cnt", mm_count, 8'd1);
      check("tol65_pout", pilot_out, 32'h0030_0031);
      for (int k = 1; k < 4; k++) send(32'h0000_3000 + 32'(k), 1'b0, 1'b0);
      drain_check("mm");
      pilot_value = '0;

      // backpressure: two data entries fill the buffer, then hold 5 cycles
      frame_length = 13'd16;
      ready_in = 1'b0;
      for (int k = 0; k < (PASS ? 2 : 3); k++) send(32'd100 + 32'(k), k == 0, (k % 4) == 0);
      check("bp_ready_drop", ready_out, 1'b0);
      idle(5);
      check("bp_ready_held", ready_out, 1'b0);
      check("bp_valid_held", valid_out, 1'b1);
      check("bp_data_held", data_out, PASS ? 32'd100 : 32'd101);
      ready_in = 1'b1;
      for (int k = (PASS ? 2 : 3); k < 16; k++) send(32'd100 + 32'(k), 1'b0, (k % 4) == 0);
      drain_check("bp");

      // resync at cnt_frame = 7
      er0 = err_cnt;
      for (int k = 0; k < 7; k++) send(32'd200 + 32'(k), k == 0, (k % 4) == 0);
      send(32'd300, 1'b1, 1'b1);
      check("resync_err", error, 1'b1);
      check("resync_pv", pilot_valid, 1'b1);
      check("resync_pout", pilot_out, 32'd300);
      fe0 = fe_cnt;
      for (int j = 1; j < 16; j++) begin
         send(32'd300 + 32'(j), 1'b0, (j % 4) == 0);
         if (j == 14) check("resync_fe_early", frame_end, 1'b0);
      end
      check("resync_fe", frame_end, 1'b1);
      drain_check("resync");
      check("resync_nfe", fe_cnt - fe0, 1);
      check("resync_nerr", err_cnt - er0, 1);

      // reset with a full skid buffer
      frame_length = 13'd0;
      ready_in = 1'b0;
      send(32'h0040_0040, 1'b1, 1'b1);
      for (int k = 0; k < (PASS ? 1 : 2); k++) send(32'h0000_4000 + 32'(k), 1'b0, 1'b0);
      check("full_mm", mm_count, 8'd1);
      check("full_ready", ready_out, 1'b0);
      rst = 1'b1;
      idle(1);
      check("flush_valid", valid_out, 1'b0);
      check("flush_mm", mm_count, 8'd0);
      rst = 1'b0;
      exp_q.delete(); exp_f.delete(); obs_q.delete(); obs_f.delete();
      idle(1);
      check("flush_ready", ready_out, 1'b1);
      ready_in = 1'b1;
      idle(3);
      check("flush_empty", obs_q.size(), 0);

      // interval 1: every sample is a pilot
      frame_length = 13'd4; pilot_interval = 13'd1;
      pv0 = pv_cnt; fe0 = fe_cnt;
      for (int k = 0; k < 4; k++) send(32'd500 + 32'(k), k == 0, 1'b1);
      drain_check("int1");
      check("int1_npilot", pv_cnt - pv0, 4);
      check("int1_nfe", fe_cnt - fe0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
